// File: rtl/cpu_run_controller.sv
// Run/debug sequencer for the CPU core: byte-loads program memory under CPU reset,
// then gates the core with a clock enable for free-run, breakpoint and single-step.
module cpu_run_controller #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CYC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  output logic              cmd_ready,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [7:0]        prog_wdata,
  output logic              cpu_rst,
  output logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic              cpu_halt,
  input  logic              bkpt_en,
  input  logic [ADDR_W-1:0] bkpt_addr,
  output logic [2:0]        state,
  output logic [CYC_W-1:0]  cyc_count,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_LOAD = 2'd0,
    C_RUN  = 2'd1,
    C_STEP = 2'd2,
    C_HALT = 2'd3
  } cmd_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CYC_W-1:0]  CYC_MAX   = '1;

  state_t            cur, nxt;
  cmd_t              cmd_code;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              skip, skip_nxt;
  logic              done_nxt;
  logic              clr_cyc;
  logic              cmd_load, cmd_run, cmd_step, cmd_halt;
  logic              byte_acc, last_byte;
  logic              bkpt_hit, stop;

  assign cmd_code  = cmd_t'(cmd);
  assign cmd_load  = cmd_valid && (cmd_code == C_LOAD);
  assign cmd_run   = cmd_valid && (cmd_code == C_RUN);
  assign cmd_step  = cmd_valid && (cmd_code == C_STEP);
  assign cmd_halt  = cmd_valid && (cmd_code == C_HALT);

  assign byte_acc  = ld_valid && ld_ready;
  assign last_byte = (ptr == LAST_ADDR);

  // skip masks the breakpoint for the first RUN cycle after a resume
  assign bkpt_hit  = bkpt_en && (cpu_pc == bkpt_addr) && !skip;
  assign stop      = cpu_halt || bkpt_hit || cmd_halt;

  assign state     = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= S_IDLE;
      ptr  <= '0;
      skip <= 1'b0;
      done <= 1'b0;
    end else begin
      cur  <= nxt;
      ptr  <= ptr_nxt;
      skip <= skip_nxt;
      done <= done_nxt;
    end
  end

  always_comb begin
    nxt      = cur;
    ptr_nxt  = ptr;
    skip_nxt = skip;
    done_nxt = 1'b0;
    clr_cyc  = 1'b0;
    case (cur)
      S_IDLE: begin
        if (cmd_load) begin
          nxt     = S_LOAD;
          ptr_nxt = '0;
        end else if (cmd_run) begin
          nxt      = S_RUN;
          skip_nxt = 1'b0;
          clr_cyc  = 1'b1;
        end else if (cmd_step) begin
          nxt     = S_STEP;
          clr_cyc = 1'b1;
        end
      end
      S_LOAD: begin
        if (byte_acc) ptr_nxt = ptr + ADDR_W'(1);
        // an abort wins over completion, but the accepted byte is still written
        if (cmd_halt) begin
          nxt = S_IDLE;
        end else if (byte_acc && last_byte) begin
          nxt      = S_IDLE;
          done_nxt = 1'b1;
        end
      end
      S_RUN: begin
        skip_nxt = 1'b0;
        if (stop) begin
          nxt      = S_PAUSE;
          done_nxt = !cmd_halt;
        end
      end
      S_STEP: begin
        if (cmd_halt) begin
          nxt = S_IDLE;
        end else begin
          nxt      = S_PAUSE;
          done_nxt = 1'b1;
        end
      end
      S_PAUSE: begin
        if (cmd_run) begin
          nxt      = S_RUN;
          skip_nxt = 1'b1;
        end else if (cmd_step) begin
          nxt = S_STEP;
        end else if (cmd_load) begin
          nxt     = S_LOAD;
          ptr_nxt = '0;
        end else if (cmd_halt) begin
          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b1;
    cpu_rst   = 1'b0;
    ld_ready  = 1'b0;
    cpu_en    = 1'b0;
    case (cur)
      S_IDLE:  cpu_rst = 1'b1;
      S_LOAD: begin
        cpu_rst  = 1'b1;
        ld_ready = 1'b1;
      end
      S_RUN:   cpu_en = !stop;
      S_STEP:  cpu_en = !cpu_halt;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
    end else begin
      prog_we <= byte_acc;
      if (byte_acc) begin
        prog_addr  <= ptr;
        prog_wdata <= ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_count <= '0;
    end else if (clr_cyc) begin
      cyc_count <= '0;
    end else if (cpu_en && (cyc_count != CYC_MAX)) begin
      cyc_count <= cyc_count + CYC_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller with a simple PC-counting CPU model.
module tb_cpu_run_controller;

  localparam logic [1:0] C_LOAD = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_STEP = 2'd2;
  localparam logic [1:0] C_HALT = 2'd3;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_STEP  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'd0;
  logic [3:0]  cpu_pc = 4'd0;
  logic        cpu_halt;
  logic        bkpt_en = 1'b0;
  logic [3:0]  bkpt_addr = 4'd0;
  logic        halt_en = 1'b0;
  logic [3:0]  halt_pc = 4'd0;

  logic        cmd_ready, ld_ready, prog_we, cpu_rst, cpu_en, done;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_wdata;
  logic [2:0]  state;
  logic [15:0] cyc_count;

  logic        cmd_ready_s, ld_ready_s, prog_we_s, cpu_rst_s, cpu_en_s, done_s;
  logic [3:0]  prog_addr_s;
  logic [7:0]  prog_wdata_s;
  logic [2:0]  state_s;
  logic [3:0]  cyc_count_s;

  int checks = 0;
  int errors = 0;
  int exp_cyc = 0;

  cpu_run_controller #(.ADDR_W(4), .CYC_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .cpu_pc(cpu_pc), .cpu_halt(cpu_halt),
    .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .state(state),
    .cyc_count(cyc_count), .done(done)
  );

  cpu_run_controller #(.ADDR_W(4), .CYC_W(4)) dut_sat (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready_s),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_s),
    .prog_we(prog_we_s), .prog_addr(prog_addr_s), .prog_wdata(prog_wdata_s),
    .cpu_rst(cpu_rst_s), .cpu_en(cpu_en_s), .cpu_pc(cpu_pc), .cpu_halt(cpu_halt),
    .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .state(state_s),
    .cyc_count(cyc_count_s), .done(done_s)
  );

  always #5 clk = ~clk;

  // CPU model: PC resets under cpu_rst and advances once per enabled cycle
  always @(posedge clk) begin
    if (cpu_rst) cpu_pc <= 4'd0;
    else if (cpu_en) cpu_pc <= cpu_pc + 4'd1;
  end
  assign cpu_halt = halt_en && (cpu_pc == halt_pc);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %0b want 1", cpu_rst); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %0b want 0", cpu_en); end
    checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL reset_prog_we: got %0b want 0", prog_we); end
    checks++; if (prog_addr !== 4'd0) begin errors++; $display("FAIL reset_prog_addr: got %0d want 0", prog_addr); end
    checks++; if (prog_wdata !== 8'd0) begin errors++; $display("FAIL reset_prog_wdata: got %0h want 0", prog_wdata); end
    checks++; if (cyc_count !== 16'd0) begin errors++; $display("FAIL reset_cyc_count: got %0d want 0", cyc_count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %0b want 0", ld_ready); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
    checks++; if ({state_s, cpu_rst_s, cpu_en_s, prog_we_s, prog_addr_s, prog_wdata_s, cyc_count_s, done_s, ld_ready_s, cmd_ready_s} !== {ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_sat_inst: state %0d cyc %0d rst %0b en %0b, want idle/0/1/0", state_s, cyc_count_s, cpu_rst_s, cpu_en_s);
    end
    reset = 1'b0;
    tick();
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_release_state: got %0d want %0d", state, ST_IDLE); end
  endtask

  task automatic test_load();
    logic [7:0] d;
    int gaps;
    send_cmd(C_LOAD);
    checks++; if (state !== ST_LOAD) begin errors++; $display("FAIL load_state: got %0d want %0d", state, ST_LOAD); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ld_ready: got %0b want 1", ld_ready); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL load_cpu_rst: got %0b want 1", cpu_rst); end
    for (int i = 0; i < 16; i++) begin
      d = 8'(16 + i);
      ld_valid = 1'b1;
      ld_data = d;
      tick();
      ld_valid = 1'b0;
      checks++; if (prog_we !== 1'b1) begin errors++; $display("FAIL load_we[%0d]: got %0b want 1", i, prog_we); end
      checks++; if (prog_addr !== 4'(i)) begin errors++; $display("FAIL load_addr[%0d]: got %0d want %0d", i, prog_addr, i); end
      checks++; if (prog_wdata !== d) begin errors++; $display("FAIL load_data[%0d]: got %0h want %0h", i, prog_wdata, d); end
      checks++; if (done !== (i == 15)) begin errors++; $display("FAIL load_done[%0d]: got %0b want %0b", i, done, (i == 15)); end
      checks++; if (state !== ((i == 15) ? ST_IDLE : ST_LOAD)) begin errors++; $display("FAIL load_state[%0d]: got %0d", i, state); end
      checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL load_rst[%0d]: got %0b want 1", i, cpu_rst); end
      gaps = 1 + int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        tick();
        checks++; if ({prog_we, done, cpu_rst} !== 3'b001) begin errors++; $display("FAIL load_gap[%0d]: we %0b done %0b rst %0b want 0 0 1", i, prog_we, done, cpu_rst); end
      end
    end
  endtask

  task automatic test_run_to_halt();
    int hp;
    hp = int'($urandom_range(3, 12));
    halt_pc = 4'(hp);
    halt_en = 1'b1;
    bkpt_en = 1'b0;
    send_cmd(C_RUN);
    checks++; if (state !== ST_RUN) begin errors++; $display("FAIL run_state: got %0d want %0d", state, ST_RUN); end
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL run_cpu_rst: got %0b want 0", cpu_rst); end
    for (int k = 0; k <= hp; k++) begin
      if (k == hp) begin
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL halt_cpu_en: got %0b want 0 at pc %0d", cpu_en, cpu_pc); end
        tick();
        checks++; if (state !== ST_PAUSE) begin errors++; $display("FAIL halt_state: got %0d want %0d", state, ST_PAUSE); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done: got %0b want 1", done); end
        checks++; if (cyc_count !== 16'(hp)) begin errors++; $display("FAIL halt_cyc: got %0d want %0d", cyc_count, hp); end
      end else begin
        checks++; if ({cpu_en, done} !== 2'b10) begin errors++; $display("FAIL run_cycle[%0d]: en %0b done %0b want 1 0", k, cpu_en, done); end
        tick();
      end
    end
    tick();
    checks++; if ({done, cpu_en, state} !== {1'b0, 1'b0, ST_PAUSE}) begin errors++; $display("FAIL halt_after: done %0b en %0b state %0d want 0 0 4", done, cpu_en, state); end
    halt_en = 1'b0;
    exp_cyc = hp;
  endtask

  task automatic test_breakpoint();
    int bk;
    send_cmd(C_HALT);
    checks++; if ({state, cpu_rst} !== {ST_IDLE, 1'b1}) begin errors++; $display("FAIL pause_halt: state %0d rst %0b want 0 1", state, cpu_rst); end
    checks++; if (cyc_count !== 16'(exp_cyc)) begin errors++; $display("FAIL pause_halt_cyc: got %0d want %0d", cyc_count, exp_cyc); end
    bk = int'($urandom_range(2, 10));
    bkpt_en = 1'b1;
    bkpt_addr = 4'(bk);
    send_cmd(C_RUN);
    checks++; if (cyc_count !== 16'd0) begin errors++; $display("FAIL bkpt_cyc_clear: got %0d want 0", cyc_count); end
    for (int k = 0; k <= bk; k++) begin
      if (k == bk) begin
        checks++; if ({cpu_en, cpu_pc} !== {1'b0, 4'(bk)}) begin errors++; $display("FAIL bkpt_stop: en %0b pc %0d want 0 %0d", cpu_en, cpu_pc, bk); end
        tick();
        checks++; if ({state, done} !== {ST_PAUSE, 1'b1}) begin errors++; $display("FAIL bkpt_pause: state %0d done %0b want 4 1", state, done); end
        checks++; if (cyc_count !== 16'(bk)) begin errors++; $display("FAIL bkpt_cyc: got %0d want %0d", cyc_count, bk); end
      end else begin
        checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL bkpt_run[%0d]: got %0b want 1", k, cpu_en); end
        tick();
      end
    end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL pause_en: got %0b want 0", cpu_en); end
    send_cmd(C_RUN);
    // resume executes the breakpoint PC, then must stop again after one full PC wrap
    for (int m = 0; m <= 16; m++) begin
      if (m == 16) begin
        checks++; if ({cpu_en, cpu_pc} !== {1'b0, 4'(bk)}) begin errors++; $display("FAIL bkpt_rehit: en %0b pc %0d want 0 %0d", cpu_en, cpu_pc, bk); end
        tick();
        checks++; if ({state, done} !== {ST_PAUSE, 1'b1}) begin errors++; $display("FAIL bkpt_rehit_pause: state %0d done %0b want 4 1", state, done); end
        checks++; if (cyc_count !== 16'(bk + 16)) begin errors++; $display("FAIL bkpt_rehit_cyc: got %0d want %0d", cyc_count, bk + 16); end
      end else begin
        checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL bkpt_resume[%0d]: got %0b want 1 (pc %0d)", m, cpu_en, cpu_pc); end
        tick();
      end
    end
    bkpt_en = 1'b0;
    exp_cyc = bk + 16;
  endtask

  task automatic test_step();
    int gap;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL step_pre_done: got %0b want 0", done); end
    for (int s = 0; s < 3; s++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        checks++; if ({cpu_en, done} !== 2'b00) begin errors++; $display("FAIL step_gap[%0d]: en %0b done %0b want 0 0", s, cpu_en, done); end
      end
      send_cmd(C_STEP);
      checks++; if ({state, cpu_en, done} !== {ST_STEP, 1'b1, 1'b0}) begin errors++; $display("FAIL step_on[%0d]: state %0d en %0b done %0b want 3 1 0", s, state, cpu_en, done); end
      tick();
      checks++; if ({state, cpu_en, done} !== {ST_PAUSE, 1'b0, 1'b1}) begin errors++; $display("FAIL step_off[%0d]: state %0d en %0b done %0b want 4 0 1", s, state, cpu_en, done); end
      checks++; if (cyc_count !== 16'(exp_cyc + s + 1)) begin errors++; $display("FAIL step_cyc[%0d]: got %0d want %0d", s, cyc_count, exp_cyc + s + 1); end
    end
    tick();
    checks++; if ({cpu_en, done} !== 2'b00) begin errors++; $display("FAIL step_end: en %0b done %0b want 0 0", cpu_en, done); end
    exp_cyc = exp_cyc + 3;
  endtask

  task automatic test_back_to_back_abort();
    logic [7:0] d;
    send_cmd(C_LOAD);
    checks++; if ({state, cpu_rst, ld_ready} !== {ST_LOAD, 1'b1, 1'b1}) begin errors++; $display("FAIL abort_load: state %0d rst %0b rdy %0b want 1 1 1", state, cpu_rst, ld_ready); end
    ld_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      ld_data = d;
      if (i == 4) begin
        cmd_valid = 1'b1;
        cmd = C_HALT;
      end
      tick();
      checks++; if ({prog_we, prog_addr, prog_wdata} !== {1'b1, 4'(i), d}) begin errors++; $display("FAIL b2b_write[%0d]: we %0b addr %0d data %0h want 1 %0d %0h", i, prog_we, prog_addr, prog_wdata, i, d); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done[%0d]: got %0b want 0", i, done); end
      checks++; if (state !== ((i == 4) ? ST_IDLE : ST_LOAD)) begin errors++; $display("FAIL abort_state[%0d]: got %0d", i, state); end
    end
    cmd_valid = 1'b0;
    ld_valid = 1'b0;
    tick();
    checks++; if ({prog_we, done, ld_ready, cpu_rst} !== 4'b0001) begin errors++; $display("FAIL abort_after: we %0b done %0b rdy %0b rst %0b want 0 0 0 1", prog_we, done, ld_ready, cpu_rst); end
    send_cmd(C_LOAD);
    d = 8'($urandom_range(0, 255));
    ld_valid = 1'b1;
    ld_data = d;
    tick();
    ld_valid = 1'b0;
    checks++; if ({prog_we, prog_addr, prog_wdata} !== {1'b1, 4'd0, d}) begin errors++; $display("FAIL reload_ptr: we %0b addr %0d data %0h want 1 0 %0h", prog_we, prog_addr, prog_wdata, d); end
    send_cmd(C_HALT);
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reload_abort: got %0d want 0", state); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    n = 3 + int'($urandom_range(0, 4));
    send_cmd(C_RUN);
    for (int k = 0; k < n; k++) begin
      checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL midrun_en[%0d]: got %0b want 1", k, cpu_en); end
      tick();
    end
    checks++; if (cyc_count !== 16'(n)) begin errors++; $display("FAIL midrun_cyc: got %0d want %0d", cyc_count, n); end
    reset = 1'b1;
    tick();
    checks++; if ({state, cpu_rst, cpu_en, done, ld_ready, cmd_ready} !== {ST_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL midrun_reset_ctl: state %0d rst %0b en %0b done %0b", state, cpu_rst, cpu_en, done);
    end
    checks++; if ({prog_we, prog_addr, prog_wdata} !== {1'b0, 4'd0, 8'd0}) begin errors++; $display("FAIL midrun_reset_prog: we %0b addr %0d data %0h want 0 0 0", prog_we, prog_addr, prog_wdata); end
    checks++; if (cyc_count !== 16'd0) begin errors++; $display("FAIL midrun_reset_cyc: got %0d want 0", cyc_count); end
    checks++; if ({state_s, cyc_count_s, prog_we_s, prog_addr_s, prog_wdata_s, done_s, ld_ready_s, cmd_ready_s, cpu_rst_s, cpu_en_s} !== {ST_IDLE, 4'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL midrun_reset_sat: state %0d cyc %0d want 0 0", state_s, cyc_count_s);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    int n;
    n = int'($urandom_range(17, 25));
    send_cmd(C_RUN);
    for (int k = 0; k < n; k++) begin
      checks++; if ({cpu_en, cpu_en_s} !== 2'b11) begin errors++; $display("FAIL sat_en[%0d]: %0b %0b want 1 1", k, cpu_en, cpu_en_s); end
      tick();
    end
    checks++; if (cyc_count !== 16'(n)) begin errors++; $display("FAIL sat_wide_cyc: got %0d want %0d", cyc_count, n); end
    checks++; if (cyc_count_s !== 4'd15) begin errors++; $display("FAIL sat_cyc: got %0d want 15", cyc_count_s); end
    cmd_valid = 1'b1;
    cmd = C_HALT;
    #1;
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL runhalt_en: got %0b want 0", cpu_en); end
    tick();
    cmd_valid = 1'b0;
    checks++; if ({state, state_s, done} !== {ST_PAUSE, ST_PAUSE, 1'b0}) begin errors++; $display("FAIL runhalt_pause: state %0d/%0d done %0b want 4 4 0", state, state_s, done); end
    checks++; if ({cyc_count, cyc_count_s} !== {16'(n), 4'd15}) begin errors++; $display("FAIL runhalt_cyc: %0d/%0d want %0d/15", cyc_count, cyc_count_s, n); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_run_to_halt();
    test_breakpoint();
    test_step();
    test_back_to_back_abort();
    test_reset_mid_run();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Run/debug sequencer that sits between the tt_um top level and the CPU core (CpuStage3). It byte-loads the CPU program memory and holds the CPU in reset while loading. It then releases the CPU and gates it with a clock enable for free-running, breakpoint-stopped or single-step execution, and counts executed cycles. Commands and load bytes arrive over valid/ready handshakes driven from the dedicated input pins.

## Interface
- ADDR_W, 4, program-memory address width (depth 2^ADDR_W bytes)
- CYC_W, 16, cycle-counter width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd  in  2  0=LOAD, 1=RUN, 2=STEP, 3=HALT
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- ld_valid  in  1  program byte offered
- ld_data  in  8  program byte
- ld_ready  out  1  byte accepted when ld_valid&ld_ready
- prog_we  out  1  program-memory write strobe
- prog_addr  out  ADDR_W  write address
- prog_wdata  out  8  write data
- cpu_rst  out  1  CPU synchronous reset, active-high
- cpu_en  out  1  CPU clock enable
- cpu_pc  in  ADDR_W  CPU program counter
- cpu_halt  in  1  CPU is executing a halt instruction
- bkpt_en  in  1  breakpoint enable
- bkpt_addr  in  ADDR_W  breakpoint PC
- state  out  3  0=IDLE, 1=LOAD, 2=RUN, 3=STEP, 4=PAUSE
- cyc_count  out  CYC_W  executed-cycle count
- done  out  1  one-cycle completion pulse

## Operation
- Reset values: state=IDLE, cpu_rst=1, cpu_en=0, prog_we=0, prog_addr=0, prog_wdata=0, cyc_count=0, done=0, ld_ready=0, cmd_ready=1.
- cmd_ready is 1 in every state. A command that is not legal in the current state is consumed and ignored.
- cpu_rst = (state==IDLE or LOAD), decoded from the state register.
- ld_ready = (state==LOAD).
- IDLE:
  - LOAD goes to LOAD and clears the write pointer to 0.
  - RUN goes to RUN, and STEP goes to STEP. Both clear cyc_count.
  - HALT has no effect.
- LOAD:
  - Each accepted byte is registered onto prog_wdata/prog_addr with prog_we=1 in the following cycle. The pointer then increments.
  - When the byte at address 2^ADDR_W-1 is accepted, the next state is IDLE, the pointer wraps to 0 and done pulses.
  - HALT aborts to IDLE with no done pulse. A byte accepted in the same cycle as HALT is still written.
  - LOAD, RUN and STEP are ignored in this state.
- RUN:
  - stop = cpu_halt | (bkpt_en & cpu_pc==bkpt_addr & !skip) | accepted HALT.
  - cpu_en = !stop. The instruction at the breakpoint or halt is not executed.
  - On stop the next state is PAUSE. done pulses unless the stop was caused by a HALT command.
  - skip is set on entering RUN from PAUSE and cleared after the first RUN cycle, so resuming from a breakpoint advances past it.
- STEP:
  - cpu_en = !cpu_halt for exactly one cycle, then the next state is PAUSE and done pulses.
  - A HALT accepted in STEP goes to IDLE.
- PAUSE:
  - cpu_en=0.
  - RUN goes to RUN (skip=1). STEP goes to STEP.
  - LOAD goes to LOAD with the pointer cleared.
  - HALT goes to IDLE. This reasserts cpu_rst; cyc_count is retained.
- cyc_count increments on every cycle with cpu_en=1 and saturates at 2^CYC_W-1.
- reset asserted in any state immediately forces all reset values on the next edge. A partial load is abandoned.

## Timing
- Command accepted at edge N gives the new state and the matching cpu_rst/ld_ready values from cycle N+1.
- From IDLE, RUN accepted at edge N gives cpu_en=1 in cycle N+1 (unless a stop condition is present).
- Load byte handshake at edge N gives prog_we=1 in cycle N+1 with that byte and address.
- Back-to-back bytes sustain one write per cycle.
- cpu_en, cpu_rst, ld_ready and cmd_ready are combinational from registered state plus cpu_halt/cpu_pc/bkpt/cmd inputs. There are no combinational paths from ld_data.
- done is registered and is high for exactly one cycle after the completing edge.
- cyc_count updates at the edge where cpu_en=1.

## Test plan
- Load: send LOAD, then 16 bytes 0x10..0x1F with an idle cycle between each pair. Required: 16 prog_we pulses at addresses 0..15 with matching data, done once, state back to IDLE, cpu_rst=1 throughout.
- Run to halt: send RUN; the CPU model raises cpu_halt when cpu_pc=9. Required: cpu_en=0 in that cycle, state=PAUSE, done pulse, cyc_count equals the number of enabled cycles.
- Breakpoint: bkpt_en=1, bkpt_addr=5, RUN. Required: stop with cpu_pc=5 and cpu_en low. A second RUN executes PC 5 and continues without re-stopping immediately.
- Step: from PAUSE issue three STEPs. Required: exactly three single-cycle cpu_en pulses, three done pulses, cyc_count+3.
- Abort/reset: HALT during LOAD after 4 bytes returns to IDLE with no done pulse. reset asserted mid-RUN gives all reset values next cycle and cyc_count=0.
- Saturation: CYC_W=4, RUN for 20 cycles. Required: cyc_count holds at 15.
